// File: rtl/alu_ctrl_sequencer.sv
// Request-side sequencer for the 64-bit datapath ALU: decodes instruction fields, drives the ALU and returns result/Zero.
// Optional macro ALU_SEQ_NOR_EN enables the class 10 / f3=100 / f7b5=1 NOR encoding (otherwise illegal).
module alu_ctrl_sequencer #(
    parameter int DATA_W  = 64,
    parameter int SHAMT_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_class,
    input  logic [2:0]        req_funct3,
    input  logic              req_f7b5,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_illegal
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // EXEC  | single ALU cycle, result captured at end of cycle
    // SHIFT | repeated doubling through the adder, cnt cycles left
    // RESP  | response held until rsp_ready
    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;

    state_t             state;
    logic [SHAMT_W-1:0] cnt;
    logic [SHAMT_W-1:0] shamt;
    logic [3:0]         dec_op;
    logic               dec_illegal;
    logic               dec_shift;

    assign shamt     = req_b[SHAMT_W-1:0];
    assign req_ready = (state == IDLE) && !reset;

    always_comb begin
        dec_op      = OP_ADD;
        dec_illegal = 1'b0;
        dec_shift   = 1'b0;
        case (req_class)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            default: begin
                case (req_funct3)
                    3'b000: dec_op = (req_class == 2'b10 && req_f7b5) ? OP_SUB : OP_ADD;
                    3'b111: dec_op = OP_AND;
                    3'b110: dec_op = OP_OR;
                    3'b001: begin
                        dec_shift   = !req_f7b5;
                        dec_illegal = req_f7b5;
                    end
`ifdef ALU_SEQ_NOR_EN
                    3'b100: begin
                        dec_op      = OP_NOR;
                        dec_illegal = !(req_class == 2'b10 && req_f7b5);
                    end
`endif
                    default: dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (dec_illegal) begin
                            rsp_valid   <= 1'b1;
                            rsp_illegal <= 1'b1;
                            rsp_result  <= '0;
                            rsp_zero    <= 1'b0;
                            state       <= RESP;
                        end else if (dec_shift && shamt != '0) begin
                            alu_a  <= req_a;
                            alu_b  <= req_a;
                            alu_op <= OP_ADD;
                            cnt    <= shamt;
                            state  <= SHIFT;
                        end else if (dec_shift) begin
                            // zero shift degenerates to a pass-through via OR with 0
                            alu_a  <= req_a;
                            alu_b  <= '0;
                            alu_op <= OP_OR;
                            state  <= EXEC;
                        end else begin
                            alu_a  <= req_a;
                            alu_b  <= req_b;
                            alu_op <= dec_op;
                            state  <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                SHIFT: begin
                    alu_a <= alu_result;
                    alu_b <= alu_result;
                    cnt   <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) begin
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_illegal <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
